// File: rtl/pe_mailbox_hub_pkg.sv
// Shared message layout helpers and message-type encodings for the PE mailbox hub.
// Field offsets are derived from the field widths so every consumer agrees on the layout.
package pe_mailbox_hub_pkg;

  typedef enum logic [2:0] {
    MSG_NONE    = 3'd0,
    MSG_REQUEST = 3'd1,
    MSG_REPLY   = 3'd2,
    MSG_TRANSIT = 3'd3,
    MSG_TERM    = 3'd4
  } msg_type_e;

  // Layout MSB->LSB: rcv_row, rcv_col, src_row, src_col, brk_row, brk_col,
  // timestamp, cost, max_hops, msg_type.
  function automatic int msg_width(input int cord_w, input int ts_w, input int cost_w,
                                   input int hop_w, input int type_w);
    return 6 * cord_w + ts_w + cost_w + hop_w + type_w;
  endfunction

  function automatic int hops_lsb(input int type_w);
    return type_w;
  endfunction

  function automatic int rcv_row_lsb(input int msg_w, input int cord_w);
    return msg_w - cord_w;
  endfunction

  function automatic int rcv_col_lsb(input int msg_w, input int cord_w);
    return msg_w - 2 * cord_w;
  endfunction

endpackage

// File: rtl/pe_mailbox_hub_msg_fifo.sv
// Per-link synchronous FIFO with occupancy count, wrap-around pointers and a clear input.
// The head entry is presented combinationally so the hub can inspect it before popping.
module msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pe_mailbox_hub.sv
// Input mailbox stage of a lattice PE: one FIFO per neighbour link, round-robin delivery
// to the core through a single output slot, and discard of expired transit messages.
module pe_mailbox_hub
  import pe_mailbox_hub_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int CORDINATE_WIDTH = 4,
  parameter int TIMESTAMP_WIDTH = 4,
  parameter int COST_WIDTH      = 4,
  parameter int MAX_HOP_WIDTH   = 4,
  parameter int MSG_TYPE_WIDTH  = 3,
  parameter int MSG_WIDTH       = msg_width(CORDINATE_WIDTH, TIMESTAMP_WIDTH, COST_WIDTH,
                                            MAX_HOP_WIDTH, MSG_TYPE_WIDTH),
  parameter int DROP_CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [CORDINATE_WIDTH-1:0]     ROW_ID,
  input  logic [CORDINATE_WIDTH-1:0]     COL_ID,
  input  logic [NUM_PORTS*MSG_WIDTH-1:0] in_value,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [MSG_WIDTH-1:0]           out_value,
  output logic [$clog2(NUM_PORTS)-1:0]   out_port,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           hub_empty,
  output logic [DROP_CNT_WIDTH-1:0]      drop_count
);

  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ROW_LSB = rcv_row_lsb(MSG_WIDTH, CORDINATE_WIDTH);
  localparam int COL_LSB = rcv_col_lsb(MSG_WIDTH, CORDINATE_WIDTH);
  localparam int HOP_LSB = hops_lsb(MSG_TYPE_WIDTH);

  logic [CNT_W-1:0]     count [NUM_PORTS];
  logic [MSG_WIDTH-1:0] head  [NUM_PORTS];
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    grant_idx;
  logic [PORT_W-1:0]    cand;
  logic                 grant_found;
  logic                 grant;
  logic                 loadable;
  logic                 drop;
  logic [MSG_WIDTH-1:0] grant_msg;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its data stable until ready, and ready never waits on valid.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign nonempty[p] = (count[p] != '0);
    assign in_ready[p] = (count[p] < CNT_W'(FIFO_DEPTH)) && !flush;
    assign push[p]     = in_valid[p] && in_ready[p];
    assign pop[p]      = grant && (grant_idx == PORT_W'(p));

    msg_fifo #(
      .WIDTH (MSG_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (push[p]),
      .push_data (in_value[p*MSG_WIDTH +: MSG_WIDTH]),
      .pop       (pop[p]),
      .head      (head[p]),
      .count     (count[p])
    );
  end

  // Scan from farthest to nearest after rr_ptr so the nearest non-empty port wins last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = PORT_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (nonempty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign loadable  = !out_valid || out_ready;
  assign grant     = grant_found && loadable && !flush;
  assign grant_msg = head[grant_idx];

  // Expired transit message: no hops left and not addressed to this PE.
  assign drop = (grant_msg[HOP_LSB +: MAX_HOP_WIDTH] == '0) &&
                ((grant_msg[ROW_LSB +: CORDINATE_WIDTH] != ROW_ID) ||
                 (grant_msg[COL_LSB +: CORDINATE_WIDTH] != COL_ID));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_port   <= '0;
      drop_count <= '0;
      rr_ptr     <= PORT_W'(NUM_PORTS - 1);
    end else if (flush) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_port  <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= grant_idx;
        if (drop && (drop_count != '1)) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
      end
      if (grant && !drop) begin
        out_valid <= 1'b1;
        out_value <= grant_msg;
        out_port  <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign hub_empty = !out_valid && (nonempty == '0);

endmodule

// File: tb/tb_pe_mailbox_hub.sv
// Directed bench for pe_mailbox_hub: stimulus tasks push expected deliveries into a queue,
// and an independent monitor pops and compares every accepted output message.
module tb_pe_mailbox_hub;

  localparam int NP = 4;
  localparam int MW = 39;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [3:0]     row_id = 4'd4;
  logic [3:0]     col_id = 4'd2;
  logic [NP*MW-1:0] in_value;
  logic [NP-1:0]  in_valid;
  logic [NP-1:0]  in_ready;
  logic [MW-1:0]  out_value;
  logic [PW-1:0]  out_port;
  logic           out_valid;
  logic           out_ready;
  logic           hub_empty;
  logic [7:0]     drop_count;

  logic [PW+MW-1:0] exp_q[$];
  logic [PW+MW-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;

  pe_mailbox_hub dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .ROW_ID     (row_id),
    .COL_ID     (col_id),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_value  (out_value),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hub_empty  (hub_empty),
    .drop_count (drop_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Message builder: rcv_row, rcv_col, src_row, src_col, brk_row, brk_col, ts, cost, hops, type
  function automatic logic [MW-1:0] mk(input logic [3:0] rr, input logic [3:0] rc,
                                       input logic [3:0] hops, input logic [7:0] tag);
    return {rr, rc, tag[7:4], tag[3:0], 4'h3, 4'h5, tag[3:0], 4'hE, hops, 3'd2};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input int p, input logic [MW-1:0] m);
    int budget = 50;
    in_value[p*MW +: MW] = m;
    in_valid[p] = 1'b1;
    @(negedge clk);
    while (!in_ready[p] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("send_timeout", 64'(in_ready[p]), 64'd1);
    @(posedge clk);
    #1 in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer is sampled at the negedge before the accepting edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_msg: unexpected port %0d value %0h, expected none", out_port, out_value);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_msg", {23'd0, out_port, out_value}, {23'd0, mon_exp});
      end
    end
  end

  initial begin
    logic [MW-1:0] m;
    logic [MW-1:0] a_msg;
    logic [MW-1:0] bp [6];

    reset = 1'b1; flush = 1'b0; in_valid = '0; in_value = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_value", 64'(out_value), 64'd0);
    check("rst_out_port", 64'(out_port), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_hub_empty", 64'(hub_empty), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'hF);

    // Single message, addressed here with zero hops: latency 2
    repeat (6) @(posedge clk);
    #1;
    m = mk(4'd4, 4'd2, 4'd0, 8'hA1);
    send(1, m);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_port", 64'(out_port), 64'd1);
    check("lat_value", 64'(out_value), 64'(m));
    check("lat_drop_count", 64'(drop_count), 64'd0);
    exp_q.push_back({2'd1, m});
    out_ready = 1'b1;
    wait_drain("single_drain");

    // Drop rule: expired message discarded, following one delivered
    exp_q.push_back({2'd0, mk(4'd1, 4'd1, 4'd2, 8'hB2)});
    send(0, mk(4'd1, 4'd1, 4'd0, 8'hB1));
    send(0, mk(4'd1, 4'd1, 4'd2, 8'hB2));
    wait_drain("drop_drain");
    check("drop_count_1", 64'(drop_count), 64'd1);
    for (int i = 0; i < 253; i++) begin
      if (i % 2 == 1) send(0, mk(4'd4, 4'd3, 4'd0, 8'(i)));
      else            send(0, mk(4'd1, 4'd1, 4'd0, 8'(i)));
    end
    repeat (3) @(posedge clk);
    #1;
    check("drop_count_254", 64'(drop_count), 64'd254);
    for (int i = 0; i < 47; i++) send(0, mk(4'd1, 4'd1, 4'd0, 8'(i)));
    repeat (3) @(posedge clk);
    #1;
    check("drop_count_sat", 64'(drop_count), 64'd255);
    check("drop_hub_empty", 64'(hub_empty), 64'd1);

    // Flush with three messages buffered
    out_ready = 1'b0;
    send(3, mk(4'd4, 4'd2, 4'd1, 8'hC0));
    send(3, mk(4'd4, 4'd2, 4'd1, 8'hC1));
    send(3, mk(4'd4, 4'd2, 4'd1, 8'hC2));
    check("flush_pre_valid", 64'(out_valid), 64'd1);
    check("flush_pre_empty", 64'(hub_empty), 64'd0);
    flush = 1'b1;
    in_value[3*MW +: MW] = mk(4'd4, 4'd2, 4'd1, 8'hCF);
    in_valid[3] = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready[3]), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid[3] = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_hub_empty", 64'(hub_empty), 64'd1);
    check("flush_drop_count", 64'(drop_count), 64'd255);
    out_ready = 1'b1;
    exp_q.push_back({2'd3, mk(4'd4, 4'd2, 4'd1, 8'hC3)});
    send(3, mk(4'd4, 4'd2, 4'd1, 8'hC3));
    wait_drain("flush_drain");

    // Backpressure: output slot occupied, port 2 fills its FIFO
    out_ready = 1'b0;
    a_msg = mk(4'd7, 4'd7, 4'd3, 8'hD0);
    exp_q.push_back({2'd0, a_msg});
    send(0, a_msg);
    for (int i = 0; i < 6; i++) begin
      bp[i] = mk(4'd2, 4'd9, 4'd5, 8'(8'hE0 + i));
      exp_q.push_back({2'd2, bp[i]});
    end
    for (int i = 0; i < 4; i++) send(2, bp[i]);
    in_value[2*MW +: MW] = bp[4];
    in_valid[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_low", 64'(in_ready[2]), 64'd0);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_value", 64'(out_value), 64'(a_msg));
    check("bp_hold_port", 64'(out_port), 64'd0);
    out_ready = 1'b1;
    send(2, bp[4]);
    send(2, bp[5]);
    wait_drain("bp_drain");

    // Fairness from reset: 3 messages on every port
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 3; k++) send(p, mk(4'd4, 4'd2, 4'd1, 8'(p * 16 + k)));
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) exp_q.push_back({2'(p), mk(4'd4, 4'd2, 4'd1, 8'(p * 16 + k))});
    check("fair_not_empty", 64'(hub_empty), 64'd0);
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("fair_hub_empty", 64'(hub_empty), 64'd1);
    check("fair_queue", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with drop_count at 5
    for (int i = 0; i < 5; i++) send(1, mk(4'd0, 4'd0, 4'd0, 8'(i)));
    repeat (3) @(posedge clk);
    #1;
    check("mid_drop_count", 64'(drop_count), 64'd5);
    out_ready = 1'b0;
    send(2, mk(4'd4, 4'd2, 4'd1, 8'h71));
    send(3, mk(4'd4, 4'd2, 4'd1, 8'h72));
    send(2, mk(4'd4, 4'd2, 4'd1, 8'h73));
    check("mid_busy", 64'(hub_empty), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_value", 64'(out_value), 64'd0);
    check("mid_out_port", 64'(out_port), 64'd0);
    check("mid_drop_cleared", 64'(drop_count), 64'd0);
    check("mid_hub_empty", 64'(hub_empty), 64'd1);
    check("mid_in_ready", 64'(in_ready), 64'hF);
    exp_q.push_back({2'd0, mk(4'd4, 4'd2, 4'd1, 8'h80)});
    exp_q.push_back({2'd3, mk(4'd4, 4'd2, 4'd1, 8'h83)});
    in_value[0 +: MW] = mk(4'd4, 4'd2, 4'd1, 8'h80);
    in_value[3*MW +: MW] = mk(4'd4, 4'd2, 4'd1, 8'h83);
    in_valid = 4'b1001;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = '0;
    wait_drain("mid_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
